// File: rtl/ccd_pkg.sv
// Shared types and geometry helpers for the linear-CCD line sequencer.
// Latency: none (package). Backpressure: none (package).
// Consumers derive per-line cycle counts from these so the top and any tooling agree.
package ccd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SH_PRE,
        ST_SH_HI,
        ST_SH_POST,
        ST_READOUT,
        ST_WAIT
    } ccd_state_t;

    function automatic int unsigned ccd_total(input int unsigned pre_cols,
                                              input int unsigned eff_cols,
                                              input int unsigned post_cols);
        return pre_cols + eff_cols + post_cols;
    endfunction

    function automatic int unsigned ccd_min_period(input int unsigned sh_pre,
                                                   input int unsigned sh_high,
                                                   input int unsigned sh_post,
                                                   input int unsigned total);
        return sh_pre + sh_high + sh_post + total;
    endfunction

endpackage

// File: rtl/ccd_line_timing_if.sv
// Control and strobe bundle between the line sequencer and its host/AFE side.
// Latency: none (wiring only). Backpressure: none; strobes are free-running.
// master drives the controls and observes strobes; slave is the sequencer.
interface ccd_line_timing_if #(
    parameter int PERIOD_W = 25
);
    logic                trigger_mode;
    logic                ext_trigger;
    logic [PERIOD_W-1:0] line_period;
    logic [PERIOD_W-1:0] exp_time;
    logic                ovr_clr;
    logic                sh_puls;
    logic                f2_puls;
    logic                rs_puls;
    logic                os_tvalid;
    logic                line_start;
    logic                busy;
    logic                overrun;

    modport master (
        output trigger_mode, ext_trigger, line_period, exp_time, ovr_clr,
        input  sh_puls, f2_puls, rs_puls, os_tvalid, line_start, busy, overrun
    );

    modport slave (
        input  trigger_mode, ext_trigger, line_period, exp_time, ovr_clr,
        output sh_puls, f2_puls, rs_puls, os_tvalid, line_start, busy, overrun
    );
endinterface

// File: rtl/ccd_trig_sync.sv
// Two-flop synchroniser for the external trigger plus rising-edge detect.
// Latency: rise is high in the 2nd cycle after the input is sampled. Backpressure: none.
// One-cycle rise pulse per synchronised low-to-high transition.
module ccd_trig_sync (
    input  logic pxl_clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);
    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge pxl_clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/ccd_line_timing.sv
// Linear-CCD line sequencer: SH / transfer / reset-gate / pixel-valid strobes per line.
// Latency: line_start 1 cycle after internal expiry, 3 cycles after ext_trigger edge; all outputs registered.
// Backpressure: none; triggers while busy are dropped and flagged on overrun. Dump shutter: CCD_LINE_TIMING_SHUTTER_EN.
module ccd_line_timing
    import ccd_pkg::*;
#(
    parameter int PRE_DUMMY_COLS  = 32,
    parameter int EFFECT_COLS     = 2048,
    parameter int POST_DUMMY_COLS = 8,
    parameter int SH_PRE          = 4,
    parameter int SH_HIGH         = 8,
    parameter int SH_POST         = 4,
    parameter int PERIOD_W        = 25
) (
    input  logic             pxl_clk,
    input  logic             rst_n,
    ccd_line_timing_if.slave bus
);
    localparam int unsigned TOTAL      = ccd_total(PRE_DUMMY_COLS, EFFECT_COLS, POST_DUMMY_COLS);
    localparam int unsigned MIN_PERIOD = ccd_min_period(SH_PRE, SH_HIGH, SH_POST, TOTAL);

    localparam logic [PERIOD_W-1:0] ONE_P      = PERIOD_W'(1);
    localparam logic [PERIOD_W-1:0] MIN_P      = PERIOD_W'(MIN_PERIOD);
    localparam logic [PERIOD_W-1:0] TOT_M1_P   = PERIOD_W'(TOTAL - 1);
    localparam logic [PERIOD_W-1:0] SH_PRE_M1  = PERIOD_W'(SH_PRE - 1);
    localparam logic [PERIOD_W-1:0] SH_HI_M1   = PERIOD_W'(SH_HIGH - 1);
    localparam logic [PERIOD_W-1:0] SH_POST_M1 = PERIOD_W'(SH_POST - 1);
    localparam logic [PERIOD_W-1:0] PIX_LO_P   = PERIOD_W'(PRE_DUMMY_COLS);
    localparam logic [PERIOD_W-1:0] PIX_HI_P   = PERIOD_W'(PRE_DUMMY_COLS + EFFECT_COLS);

    ccd_state_t          state, state_nxt;
    logic [PERIOD_W-1:0] ph_cnt, ph_cnt_nxt;
    logic [PERIOD_W-1:0] per_cnt, per_cnt_nxt;
    logic [PERIOD_W-1:0] period_q, period_nxt;
    logic                trig_rise, ext_start, start, int_expire;
    logic                sh_nxt, rd_nxt, tv_nxt, busy_nxt, ovr_nxt, dump_nxt;

    ccd_trig_sync u_trig_sync (
        .pxl_clk  (pxl_clk),
        .rst_n    (rst_n),
        .async_in (bus.ext_trigger),
        .rise     (trig_rise)
    );

    assign ext_start  = bus.trigger_mode & trig_rise;
    assign int_expire = (per_cnt == period_q - ONE_P);

    always_ff @(posedge pxl_clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            ph_cnt   <= '0;
            per_cnt  <= '0;
            period_q <= '0;
        end else begin
            state    <= state_nxt;
            ph_cnt   <= ph_cnt_nxt;
            per_cnt  <= per_cnt_nxt;
            period_q <= period_nxt;
        end
    end

    // A minimum-length internal line leaves READOUT straight into the next line so periods stay exact.
    always_comb begin
        state_nxt  = state;
        ph_cnt_nxt = ph_cnt + ONE_P;
        start      = 1'b0;
        case (state)
            ST_IDLE: begin
                ph_cnt_nxt = '0;
                start      = bus.trigger_mode ? trig_rise : 1'b1;
            end
            ST_SH_PRE:  if (ph_cnt == SH_PRE_M1)  begin state_nxt = ST_SH_HI;   ph_cnt_nxt = '0; end
            ST_SH_HI:   if (ph_cnt == SH_HI_M1)   begin state_nxt = ST_SH_POST; ph_cnt_nxt = '0; end
            ST_SH_POST: if (ph_cnt == SH_POST_M1) begin state_nxt = ST_READOUT; ph_cnt_nxt = '0; end
            ST_READOUT: begin
                if (ph_cnt == TOT_M1_P) begin
                    ph_cnt_nxt = '0;
                    if (bus.trigger_mode)  state_nxt = ST_IDLE;
                    else if (int_expire)   start     = 1'b1;
                    else                   state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                ph_cnt_nxt = '0;
                if (bus.trigger_mode)  state_nxt = ST_IDLE;
                else if (int_expire)   start     = 1'b1;
            end
            default: begin
                state_nxt  = ST_IDLE;
                ph_cnt_nxt = '0;
            end
        endcase
        if (start) begin
            state_nxt  = ST_SH_PRE;
            ph_cnt_nxt = '0;
        end
        per_cnt_nxt = start ? '0 : ((state == ST_IDLE) ? per_cnt : per_cnt + ONE_P);
        period_nxt  = period_q;
        if (start)
            period_nxt = (bus.line_period < MIN_P) ? MIN_P : bus.line_period;
    end

`ifdef CCD_LINE_TIMING_SHUTTER_EN
    logic                dump_en_q, dump_en_nxt;
    logic [PERIOD_W-1:0] dump_at_q, dump_at_nxt, dump_at_calc;

    always_ff @(posedge pxl_clk or negedge rst_n) begin
        if (!rst_n) begin
            dump_en_q <= 1'b0;
            dump_at_q <= '0;
        end else begin
            dump_en_q <= dump_en_nxt;
            dump_at_q <= dump_at_nxt;
        end
    end

    // Dump geometry is frozen at line start; it must land wholly after READOUT, i.e. in WAIT.
    always_comb begin
        dump_at_calc = period_nxt - bus.exp_time - PERIOD_W'(SH_HIGH);
        dump_en_nxt  = dump_en_q;
        dump_at_nxt  = dump_at_q;
        if (start) begin
            dump_at_nxt = dump_at_calc;
            dump_en_nxt = !bus.trigger_mode && (bus.exp_time < period_nxt - MIN_P) &&
                          (dump_at_calc >= MIN_P);
        end
        dump_nxt = dump_en_nxt && (state_nxt == ST_WAIT) && (per_cnt_nxt >= dump_at_nxt) &&
                   (per_cnt_nxt < dump_at_nxt + PERIOD_W'(SH_HIGH));
    end
`else
    logic unused_exp;
    assign unused_exp = ^bus.exp_time;
    assign dump_nxt   = 1'b0;
`endif

    always_comb begin
        rd_nxt   = (state_nxt == ST_READOUT);
        sh_nxt   = (state_nxt == ST_SH_HI) | dump_nxt;
        tv_nxt   = rd_nxt && (ph_cnt_nxt >= PIX_LO_P) && (ph_cnt_nxt < PIX_HI_P);
        busy_nxt = (state_nxt != ST_IDLE) &&
                   !(!bus.trigger_mode && !start && (per_cnt_nxt == period_nxt - ONE_P));
        ovr_nxt  = bus.overrun;
        if (bus.ovr_clr)            ovr_nxt = 1'b0;
        if (ext_start && bus.busy)  ovr_nxt = 1'b1;
    end

    always_ff @(posedge pxl_clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.sh_puls    <= 1'b0;
            bus.f2_puls    <= 1'b0;
            bus.rs_puls    <= 1'b0;
            bus.os_tvalid  <= 1'b0;
            bus.line_start <= 1'b0;
            bus.busy       <= 1'b0;
            bus.overrun    <= 1'b0;
        end else begin
            bus.sh_puls    <= sh_nxt;
            bus.f2_puls    <= rd_nxt;
            bus.rs_puls    <= rd_nxt;
            bus.os_tvalid  <= tv_nxt;
            bus.line_start <= start;
            bus.busy       <= busy_nxt;
            bus.overrun    <= ovr_nxt;
        end
    end

endmodule

// File: doc/ccd_line_timing.md
# ccd_line_timing

Parametrised linear-CCD line sequencer: generates SH, transfer-phase, reset-gate and pixel-valid strobes for one sensor line per trigger, with pixel counts, SH pulse geometry and line period set by parameters and ports. It sits between the clock generator and the AFE driver (`os_tvalid` feeds the AD9945 path). It generalises the fixed TCD1209D sequencer to any dummy/effective column split. It adds:
- period clamping;
- overrun reporting;
- an optional electronic shutter.

## Interface
- `PRE_DUMMY_COLS`, 32 — leading dummy pixels per line
- `EFFECT_COLS`, 2048 — effective pixels per line
- `POST_DUMMY_COLS`, 8 — trailing dummy pixels per line
- `SH_PRE`, 4 — cycles from line start to SH rise
- `SH_HIGH`, 8 — SH high width, cycles
- `SH_POST`, 4 — cycles from SH fall to first transfer cycle
- `PERIOD_W`, 25 — width of period/exposure counters

Ports:
- `pxl_clk` in 1 — pixel clock, the only clock
- `rst_n` in 1 — asynchronous active-low reset
- `trigger_mode` in 1 — 1 = external trigger, 0 = internal free-run
- `ext_trigger` in 1 — asynchronous trigger, rising edge active
- `line_period` in PERIOD_W — internal-mode line period, cycles
- `exp_time` in PERIOD_W — shutter exposure, cycles (used only with the shutter macro)
- `ovr_clr` in 1 — clears `overrun`
- `sh_puls` out 1 — SH gate
- `f2_puls` out 1 — transfer-phase enable, gated externally with the phase clock
- `rs_puls` out 1 — reset-gate/clamp enable
- `os_tvalid` out 1 — high on effective pixels only
- `line_start` out 1 — one-cycle pulse at line start
- `busy` out 1 — high from line start until the next line can start
- `overrun` out 1 — sticky; a trigger arrived while `busy`

## Operation
- `TOTAL = PRE_DUMMY_COLS+EFFECT_COLS+POST_DUMMY_COLS`.
- `MIN_PERIOD = SH_PRE+SH_HIGH+SH_POST+TOTAL`.
- FSM states are IDLE, SH_PRE, SH_HI, SH_POST, READOUT and WAIT.
- IDLE → SH_PRE on a start event:
  - internal mode: period counter expiry;
  - external mode: synchronised rising edge of `ext_trigger`.
  - `line_start` pulses in the transition cycle.
- SH_PRE → SH_HI → SH_POST after `SH_PRE`, `SH_HIGH` and `SH_POST` cycles respectively. `sh_puls` = 1 only in SH_HI.
- READOUT lasts exactly `TOTAL` cycles. `f2_puls` = `rs_puls` = 1 throughout. Pixel index p = 0..TOTAL-1. `os_tvalid` = 1 iff `PRE_DUMMY_COLS` ≤ p < `PRE_DUMMY_COLS+EFFECT_COLS`.
- READOUT → WAIT in internal mode; → IDLE in external mode.
- WAIT holds until the period counter reaches the latched period, then starts the next line directly (→ SH_PRE with `line_start`).
- The period is latched at line start as max(`line_period`, `MIN_PERIOD`). Values of 0 or below the minimum clamp; they never stall.
- The period counter counts from line start and is `PERIOD_W` wide. It never wraps, because the latched period is at most 2^PERIOD_W−1.
- A start event while `busy` is ignored for sequencing and sets `overrun`.
- `ovr_clr` clears `overrun`. If `ovr_clr` and a new overrun occur in the same cycle, set wins.
- Switching `trigger_mode` takes effect at the next IDLE/WAIT decision. The current line always completes.
- On `rst_n` assertion (including mid-line), go to IDLE immediately and drive all outputs 0. After release in internal mode, the first line starts 1 cycle later.

## Timing
- All outputs are registered, and all reset to 0.
- `ext_trigger` passes through a 2-flop synchroniser plus an edge detector. Latency from the input edge to `line_start` is 3 cycles.
- `sh_puls` rises `SH_PRE` cycles after `line_start`.
- The first `f2_puls` cycle is `SH_PRE+SH_HIGH+SH_POST` cycles after `line_start`.
- The first `os_tvalid` comes `PRE_DUMMY_COLS` cycles after that.
- In internal mode, consecutive `line_start` pulses are exactly the latched period apart.
- `busy` rises with `line_start`:
  - internal mode: falls in the cycle before the next `line_start`;
  - external mode: falls after the last READOUT cycle.

## Configuration
- Macro `CCD_LINE_TIMING_SHUTTER_EN`.
- When defined:
  - an extra `SH_HIGH`-wide SH pulse (charge dump) fires at cycle `period − exp_time − SH_HIGH` of each internal-mode line;
  - this limits exposure to `exp_time`;
  - the dump pulse is suppressed if `exp_time` ≥ `period − MIN_PERIOD`, or if the pulse would overlap READOUT;
  - external mode is unaffected.
- When undefined:
  - the `exp_time` port exists but is ignored;
  - no dump logic is synthesised;
  - exposure equals the line period.

## Structure
- Shared package `ccd_pkg` holds:
  - the FSM state enum `ccd_state_t`;
  - the `TOTAL`/`MIN_PERIOD` computation functions.
- One sub-module, `ccd_trig_sync`: 2-flop synchroniser plus rising-edge detector, with async active-low reset.
- The sequencer counters and FSM live in the top module.

## Test plan
Parameters for all scenarios: PRE=2, EFFECT=8, POST=1, SH_PRE=2, SH_HIGH=4, SH_POST=2, so MIN_PERIOD=19.
- Internal mode, `line_period`=40 → `line_start` every 40 cycles; `sh_puls` high at line cycles 2–5; `f2_puls` at 8–18; `os_tvalid` at 10–17.
- Internal mode, `line_period`=5 → period clamped to 19; no `overrun`.
- External mode, edge at t → `line_start` at t+3; second edge at t+10 → `overrun`=1 and no restart; `ovr_clr` → 0.
- `rst_n` low mid-READOUT → all outputs 0 asynchronously; after release, internal mode restarts cleanly from SH_PRE.
- Shutter macro defined, period=60, `exp_time`=20 → dump SH at line cycles 36–39 plus the normal SH at 2–5.
- Shutter macro defined, `exp_time`=50 → no dump pulse.
